// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The optional majority-vote sampler is selected with UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } uart_rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DATA_W_MIN     = 5;
  localparam int DATA_W_MAX     = 9;
  localparam int OVERSAMPLE_MIN = 8;

  function automatic bit data_w_legal(input int w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
  endfunction

  function automatic bit oversample_legal(input int os);
    return (os >= OVERSAMPLE_MIN) && ((os % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-word handshake between the UART receiver and its consumer.
// A word transfers on a clk edge where rx_valid && rx_ready; rx_valid, once
// raised, stays high with rx_data and the error flags stable until that edge.
interface uart_rx_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_error;
  logic              parity_error;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_error,
    output parity_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  parity_error,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every div+1 clocks, restartable.
module uart_baud_tick #(
  parameter int DIV_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // Clearing to zero makes the first tick land in the cycle after clear.
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start detection, oversampled bit sampling, parity and
// stop checks, and a held output word. UART_RX_MAJORITY_EN enables 2-of-3 voting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop_bits2,
  output logic             overrun_error,
  output logic             busy,
  output uart_rx_state_e   state_dbg,
  uart_rx_core_if.master   rx_if
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(OVERSAMPLE / 2);
`endif

  if (!data_w_legal(DATA_W) || !oversample_legal(OVERSAMPLE)) begin : g_bad_cfg
    $error("uart_rx_core: DATA_W or OVERSAMPLE out of range");
  end

  uart_rx_state_e    state_q, state_d;
  logic              rx_s1, rx_s2, rx_prev;
  logic              fall, tick, samp, bit_v;
  logic              start_frame, done, fe_final;
  logic [DIV_W-1:0]  div_q;
  logic              par_en_q, par_odd_q, stop2_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic              frame_err_q, par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Edge-only start detection also keeps a held break from re-triggering.
  assign fall = rx_prev & ~rx_s2;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_frame),
    .div   (div_q),
    .tick  (tick)
  );

  assign samp = tick && (bit_cnt_q == CNT_DECIDE) && (state_q != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_q <= 2'b11;
    end else if (tick && (bit_cnt_q == CNT_EARLY)) begin
      early_q[0] <= rx_s2;
    end else if (tick && (bit_cnt_q == CNT_MID)) begin
      early_q[1] <= rx_s2;
    end
  end

  assign bit_v = (early_q[0] & early_q[1]) | (early_q[0] & rx_s2) | (early_q[1] & rx_s2);
`else
  assign bit_v = rx_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    done        = 1'b0;
    fe_final    = frame_err_q | ~bit_v;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          start_frame = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (samp) state_d = bit_v ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (samp && (bit_idx_q == IDX_LAST)) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (samp) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (samp) begin
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (samp) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= PARITY_EVEN;
      stop2_q     <= 1'b0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      if (start_frame) begin
        div_q       <= baud_div;
        par_en_q    <= parity_en;
        par_odd_q   <= parity_odd ? PARITY_ODD : PARITY_EVEN;
        stop2_q     <= stop_bits2;
        bit_cnt_q   <= '0;
        bit_idx_q   <= '0;
        frame_err_q <= 1'b0;
        par_err_q   <= 1'b0;
      end else if (tick) begin
        bit_cnt_q <= (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
      end
      if (samp) begin
        case (state_q)
          ST_DATA: begin
            shreg_q   <= {bit_v, shreg_q[DATA_W-1:1]};
            bit_idx_q <= bit_idx_q + IDX_W'(1);
          end
          ST_PARITY:         par_err_q   <= ((^shreg_q) ^ bit_v) != par_odd_q;
          ST_STOP, ST_STOP2: frame_err_q <= fe_final;
          default: ;
        endcase
      end
    end
  end

  // A completed word is dropped, not queued, while the held one is unread.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.rx_data      <= '0;
      rx_if.rx_valid     <= 1'b0;
      rx_if.frame_error  <= 1'b0;
      rx_if.parity_error <= 1'b0;
      overrun_error      <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (done) begin
        if (!rx_if.rx_valid || rx_if.rx_ready) begin
          rx_if.rx_data      <= shreg_q;
          rx_if.frame_error  <= fe_final;
          rx_if.parity_error <= par_err_q;
          rx_if.rx_valid     <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized checks of uart_rx_core against a frame-level model.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int W = 10;  // {frame_error, parity_error, data[7:0]}

  logic           clk;
  logic           rst_n;
  logic           rx;
  logic [12:0]    baud_div;
  logic           parity_en;
  logic           parity_odd;
  logic           stop_bits2;
  logic           overrun_error;
  logic           busy;
  uart_rx_state_e state_dbg;

  uart_rx_core_if #(.DATA_W(8)) rx_if ();

  uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(13)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .stop_bits2    (stop_bits2),
    .overrun_error (overrun_error),
    .busy          (busy),
    .state_dbg     (state_dbg),
    .rx_if         (rx_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  int rise_cnt = 0;
  int ovr_cnt = 0;
  int bit_clk = 16;
  logic valid_prev = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame-level reference: data unchanged, parity counts ones, any low stop bit is a frame error
  function automatic logic [W-1:0] model(input logic [7:0] d, input bit pen, input bit odd,
                                         input bit pbit, input bit s1, input bit s2, input bit two);
    bit fe, pe;
    fe = !s1 || (two && !s2);
    pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
    return {fe, pe, d};
  endfunction

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (bit_clk) step();
  endtask

  task automatic send(input logic [7:0] d, input bit pen, input bit odd, input bit pbit,
                      input bit s1, input bit s2, input bit two, input bit push);
    parity_en  = pen;
    parity_odd = odd;
    stop_bits2 = two;
    if (push) exp_q.push_back(model(d, pen, odd, pbit, s1, s2, two));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rx_if.rx_valid && !valid_prev) rise_cnt++;
    valid_prev = rx_if.rx_valid;
    if (overrun_error) ovr_cnt++;
    if (rx_if.rx_valid && rx_if.rx_ready) begin
      check("sb_have_exp", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sb_word", {rx_if.frame_error, rx_if.parity_error, rx_if.rx_data}, exp_w);
      end
    end
  end

  initial begin
    int r0, waited;
    logic [7:0] d;
    bit pen, odd, pbit, s1, s2, two;

    rst_n = 1'b0;
    rx = 1'b1;
    baud_div = '0;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop_bits2 = 1'b0;
    rx_if.rx_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.rx_data, 0);
    check("rst_flags", {rx_if.frame_error, rx_if.parity_error, overrun_error}, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    idle(20);

    // 8N1 basic
    r0 = rise_cnt;
    send(8'hA5, 0, 0, 0, 1, 1, 0, 1);
    idle(32);
    check("8n1_one_valid", rise_cnt - r0, 1);
    check("8n1_busy_low", busy, 0);
    check("8n1_data_held", rx_if.rx_data, 8'hA5);

    // parity: even, 0x07 with wrong then right parity bit
    send(8'h07, 1, 0, 0, 1, 1, 0, 1);
    idle(8);
    check("par_bad_flag", rx_if.parity_error, 1);
    send(8'h07, 1, 0, 1, 1, 1, 0, 1);
    idle(8);
    check("par_good_flag", rx_if.parity_error, 0);

    // frame error, then break, then recovery
    r0 = rise_cnt;
    send(8'h3C, 0, 0, 0, 0, 1, 0, 1);
    check("fe_flag", rx_if.frame_error, 1);
    repeat (100) step();
    check("break_no_valid", rise_cnt - r0, 1);
    idle(32);
    send(8'h3C, 0, 0, 0, 1, 1, 0, 1);
    idle(8);
    check("after_break_valid", rise_cnt - r0, 2);
    check("after_break_fe", rx_if.frame_error, 0);

    // false start
    r0 = rise_cnt;
    rx = 1'b0;
    repeat (4) step();
    check("fs_busy_seen", busy, 1);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 16) begin
      step();
      waited++;
    end
    check("fs_busy_drop", busy, 0);
    idle(32);
    check("fs_no_valid", rise_cnt - r0, 0);

    // overrun
    rx_if.rx_ready = 1'b0;
    r0 = ovr_cnt;
    send(8'h11, 0, 0, 0, 1, 1, 0, 1);
    idle(4);
    send(8'h22, 0, 0, 0, 1, 1, 0, 0);
    idle(8);
    check("ovr_valid_held", rx_if.rx_valid, 1);
    check("ovr_data_held", rx_if.rx_data, 8'h11);
    check("ovr_pulse_once", ovr_cnt - r0, 1);
    rx_if.rx_ready = 1'b1;
    step();
    check("ovr_valid_clear", rx_if.rx_valid, 0);
    check("ovr_data_kept", rx_if.rx_data, 8'h11);

    // reset during the 4th data bit
    r0 = rise_cnt;
    parity_en = 1'b0;
    stop_bits2 = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (8) step();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check("mrst_outputs", {rx_if.rx_valid, rx_if.frame_error, rx_if.parity_error, overrun_error, busy}, 0);
    check("mrst_data", rx_if.rx_data, 0);
    step();
    rst_n = 1'b1;
    idle(40);
    check("mrst_no_valid", rise_cnt - r0, 0);
    send(8'h5A, 0, 0, 0, 1, 1, 1, 1);
    idle(8);
    check("mrst_next_valid", rise_cnt - r0, 1);
    check("mrst_next_data", rx_if.rx_data, 8'h5A);

    // randomized frames across configurations
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      pen  = bit'($urandom_range(0, 1));
      odd  = bit'($urandom_range(0, 1));
      two  = bit'($urandom_range(0, 1));
      pbit = bit'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      baud_div = 13'($urandom_range(0, 3));
      bit_clk  = 16 * (int'(baud_div) + 1);
      send(d, pen, odd, pbit, s1, s2, two, 1);
      idle($urandom_range(2, 20));
    end
    bit_clk = 16;
    idle(64);
    check("sb_drained", exp_q.size(), 0);
    check("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine with programmable data width, oversampling factor, runtime parity and stop-bit modes, and a valid/ready output handshake with overrun detection. It sits between the synchronised serial `rx` pin and the RX data path or FIFO. It is the next-generation receiver behind the UART bench's `rx`, `rx_valid`, `frame_error`, `parity_error`, `parity_en` and `baud_rate` signals.

## Interface

**Parameters**

- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: ticks per bit; even, at least 8.
- `DIV_W`, default 13: width of `baud_div`.

**Ports** (name, direction, width, meaning)

- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `rx` input 1: asynchronous serial line; idles high.
- `baud_div` input `DIV_W`: oversample tick every `baud_div`+1 clk cycles.
- `parity_en` input 1: parity bit present.
- `parity_odd` input 1: 1 selects odd parity, 0 selects even.
- `stop_bits2` input 1: 1 selects two stop bits.
- `rx_ready` input 1: consumer accepts `rx_data`.
- `rx_data` output `DATA_W`: received word, LSB-first on the line.
- `rx_valid` output 1: word held until handshake.
- `frame_error` output 1: qualified by `rx_valid`.
- `parity_error` output 1: qualified by `rx_valid`.
- `overrun_error` output 1: one-cycle pulse.
- `busy` output 1: FSM not in IDLE.

## Operation

- `rx` passes through a 2-flop synchroniser (reset value 1), then a falling-edge detector.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, STOP2.
- **IDLE:**
  - On a synchronised 1→0 edge: latch `baud_div`, `parity_en`, `parity_odd` and `stop_bits2`; clear the tick divider and bit-tick counter; go to START.
  - Configuration changes mid-frame are ignored.
- **Sample point:** bit-tick counter value `OVERSAMPLE`/2, counting 0..`OVERSAMPLE`-1 and wrapping each bit.
- **START:** sample = 1 is a false start; return to IDLE, no outputs. Sample = 0 goes to DATA.
- **DATA:**
  - Shift samples into the shift register LSB first.
  - After `DATA_W` samples, go to PARITY if parity is enabled, otherwise STOP.
- **PARITY:** error if XOR(data, parity bit) ≠ `parity_odd`.
- **STOP:** sample 0 sets the frame error. If `stop_bits2` is set go to STOP2 (same check), otherwise complete.
- **Completion:**
  - The FSM returns to IDLE at the final stop-bit sample point; it does not wait for the bit end.
  - If `rx_valid` is 0 or the handshake completes this cycle: load `rx_data`, `frame_error` and `parity_error`, and set `rx_valid`.
  - Otherwise drop the new word, keep the held word and flags, and pulse `overrun_error`.
- **Handshake:** `rx_valid`&&`rx_ready` clears `rx_valid` next cycle. `rx_data` and the flags hold their value until the next load.
- **Break:** with `rx` held low after a frame error, no new frame starts until `rx` has been seen high (edge detection).

## Timing

- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_error`=0, `parity_error`=0, `overrun_error`=0, `busy`=0; FSM in IDLE; synchroniser = 1.
- `rst_n` asserted mid-frame aborts immediately. No partial word is delivered.
- **Input latency:** 2 clk from `rx` to the synchroniser output; START is entered 1 clk after the edge is detected.
- **Bit period:** `OVERSAMPLE`×(`baud_div`+1) clk. With `baud_div`=0 a tick occurs every clk.
- **Output latency:** `rx_valid` rises 1 clk after the final stop-bit sample tick.
- `busy` falls in the same cycle that `rx_valid` rises.
- A back-to-back start edge is accepted from the first IDLE cycle onward.

## Configuration

- **`UART_RX_MAJORITY_EN` defined:**
  - Each bit value is the 2-of-3 majority of samples at ticks `OVERSAMPLE`/2-1, `OVERSAMPLE`/2 and `OVERSAMPLE`/2+1.
  - The decision is taken at tick `OVERSAMPLE`/2+1, so the completion latency grows by one tick.
- **Undefined:** single sample at tick `OVERSAMPLE`/2.

## Structure

- **`uart_pkg`:**
  - `uart_rx_state_e` enum.
  - Parity-mode constants.
  - Localparam helpers for `DATA_W` and `OVERSAMPLE` range checks.
- **Sub-module `uart_baud_tick`:**
  - `DIV_W`-bit down-counter producing a one-clk tick.
  - Synchronous clear input, driven by start detection.
  - Reused later by the transmitter.

## Test plan

All scenarios use `DATA_W`=8, `OVERSAMPLE`=16, `baud_div`=0 (bit = 16 clk).

- **8N1 basic:** 8N1 frame 0xA5 with `rx_ready`=1 → a single `rx_valid` with `rx_data`=0xA5, both error flags 0, `busy` low afterwards.
- **Parity error:** even parity, data 0x07, parity bit driven 0 → `rx_valid` with `rx_data`=0x07 and `parity_error`=1. The same frame with parity bit 1 → `parity_error`=0.
- **Frame error and break:**
  - Frame 0x3C with stop bit 0 → `frame_error`=1.
  - `rx` then held low for 100 clk → no further `rx_valid`.
  - `rx` high, then frame 0x3C → clean receive.
- **False start:** `rx` low for 4 clk, then high → no `rx_valid`; `busy` returns to 0 within 16 clk.
- **Overrun:**
  - `rx_ready`=0; frames 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun_error` pulses exactly once.
  - `rx_ready`=1 → `rx_valid` clears the next cycle.
- **Reset mid-frame:** `rst_n` pulsed during the 4th data bit → all outputs 0. The next frame 0x5A with `stop_bits2`=1 is received correctly.
